tros_meas_sequencer: RTL and testbench
======================================

TROS_MEAS_SEQUENCER -- requirements
Module: tros_meas_sequencer

Interface
REQ-001 SHALL have parameter COUNTER_LENGTH, default 20, width of each latched oscillator count.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, clk cycles latch_counter is held high before counts are sampled (min 1).
REQ-003 SHALL have port clk  input  1  single clock for all state; rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port start  input  1  begin a measurement run; sampled only in IDLE.
REQ-006 SHALL have port continuous  input  1  when high at run end, start the next run without returning to IDLE.
REQ-007 SHALL have port gate_len  input  16  gate window length in clk cycles.
REQ-008 SHALL have ports count0, count1, count2  input  COUNTER_LENGTH  latched counts of oscillators 0..2.
REQ-009 SHALL have port ctr_reset  output  1  clears the oscillator counters.
REQ-010 SHALL have port latch_counter  output  1  latches the oscillator counters.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port tx_data  output  1  Manchester-encoded serial frame.
REQ-013 SHALL have port tx_valid  output  1  high while a frame bit is being driven.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after the third frame of a run.

Function
REQ-015 SHALL implement states IDLE, CLEAR, GATE, LATCH, LOAD, SHIFT.
REQ-016 IDLE: start=1 at a clk edge SHALL enter CLEAR; start SHALL be ignored in all other states.
REQ-017 CLEAR SHALL last exactly 2 cycles with ctr_reset=1, then enter GATE; ctr_reset SHALL be 0 in all other states.
REQ-018 GATE SHALL last max(gate_len,1) cycles, gate_len sampled on CLEAR entry, then enter LATCH.
REQ-019 LATCH SHALL hold latch_counter=1 for SETTLE_CYCLES cycles, then enter LOAD with channel index 0; latch_counter SHALL be 0 elsewhere.
REQ-020 LOAD SHALL last 1 cycle, capturing the frame {4'b1010, ch[1:0], count_ch, P}, where P = XOR of count_ch (even parity over count bits); frame width COUNTER_LENGTH+7 (27 by default).
REQ-021 SHIFT SHALL send frame bits MSB first, 2 clk cycles per bit: first half tx_data = ~bit, second half tx_data = bit (0 = high-to-low, 1 = low-to-high).
REQ-022 tx_valid SHALL be 1 exactly during SHIFT; tx_data SHALL be 0 whenever tx_valid=0.
REQ-023 After the last bit: if ch<2, increment ch and enter LOAD; if ch=2, pulse frame_done for 1 cycle and enter CLEAR if continuous=1, else IDLE.
REQ-024 continuous SHALL be sampled only in the final SHIFT cycle of channel 2.
REQ-025 A run SHALL occupy 2 + G + SETTLE_CYCLES + 3*(1 + 2*(COUNTER_LENGTH+7)) cycles, G = max(gate_len,1).
REQ-026 count inputs SHALL be sampled only in LOAD; changes at other times SHALL not affect the frame.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, ch=0, cleared shift register and bit counters, and all outputs 0, including mid-run and mid-frame.
REQ-028 After rst_n deasserts, the first start SHALL be honoured at the first clk edge where start=1.

Verification
REQ-029 Reset mid-SHIFT (bit 10 of channel 1) -> all outputs 0 same cycle; busy=0; next start runs cleanly from channel 0.
REQ-030 gate_len=5, SETTLE_CYCLES=4, count0=0x12345, start pulse -> ctr_reset high 2 cycles, latch high cycles 8..11 after start, first frame decodes 1010_00_0001_0010_0011_0100_0101_1 (P=1).
REQ-031 gate_len=0 -> GATE lasts 1 cycle; run length 2+1+4+3*55 = 172 cycles; frame_done pulses once.
REQ-032 count1=0xFFFFF, count2=0 -> frame 1 parity 0, frame 2 parity 0; ch fields 01 and 10; tx_valid low in the 1 LOAD cycle between frames.
REQ-033 continuous=1 during final bit -> CLEAR follows frame_done with no IDLE cycle, busy stays 1; continuous=0 -> IDLE, busy=0.
REQ-034 start held high during a run, and count inputs toggling outside LOAD -> no restart, frames unchanged.

Source files
------------

// File: rtl/tros_meas_sequencer.sv
// TROS measurement sequencer: clear, gate, latch, then
// ships three Manchester-coded count frames per run.
module tros_meas_sequencer #(
  parameter int COUNTER_LENGTH = 20,
  parameter int SETTLE_CYCLES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      continuous,
  input  logic [15:0]               gate_len,
  input  logic [COUNTER_LENGTH-1:0] count0,
  input  logic [COUNTER_LENGTH-1:0] count1,
  input  logic [COUNTER_LENGTH-1:0] count2,
  output logic                      ctr_reset,
  output logic                      latch_counter,
  output logic                      busy,
  output logic                      tx_data,
  output logic                      tx_valid,
  output logic                      frame_done
);

  localparam int FW = COUNTER_LENGTH + 7;
  localparam int BW = $clog2(FW + 1);

  typedef enum logic [2:0] {
    IDLE, CLEAR, GATE, LATCH, LOAD, SHIFT
  } state_t;

  state_t                    state;
  logic [15:0]               cnt;
  logic [15:0]               glen;
  logic [1:0]                ch;
  logic [FW-1:0]             sr;
  logic [BW-1:0]             bits;
  logic                      half;
  logic [COUNTER_LENGTH-1:0] sel;
  logic [FW-1:0]             frame;
  logic [15:0]               glen_in;

  // Frame for the current channel, built from live counts.
  always_comb begin
    sel = count0;
    unique case (ch)
      2'd0:    sel = count0;
      2'd1:    sel = count1;
      default: sel = count2;
    endcase
    frame   = {4'b1010, ch, sel, ^sel};
    glen_in = (gate_len == 16'd0) ? 16'd1 : gate_len;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      glen          <= 16'd1;
      ch            <= '0;
      sr            <= '0;
      bits          <= '0;
      half          <= 1'b0;
      ctr_reset     <= 1'b0;
      latch_counter <= 1'b0;
      busy          <= 1'b0;
      tx_data       <= 1'b0;
      tx_valid      <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= CLEAR;
            cnt       <= '0;
            glen      <= glen_in;
            ctr_reset <= 1'b1;
            busy      <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt == 16'd1) begin
            state     <= GATE;
            cnt       <= '0;
            ctr_reset <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        GATE: begin
          if (cnt == glen - 16'd1) begin
            state         <= LATCH;
            cnt           <= '0;
            latch_counter <= 1'b1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        LATCH: begin
          if (cnt == 16'(SETTLE_CYCLES - 1)) begin
            state         <= LOAD;
            cnt           <= '0;
            ch            <= '0;
            latch_counter <= 1'b0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        LOAD: begin
          state    <= SHIFT;
          sr       <= frame;
          bits     <= BW'(FW - 1);
          half     <= 1'b0;
          tx_valid <= 1'b1;
          tx_data  <= ~frame[FW-1];
        end
        SHIFT: begin
          if (!half) begin
            half    <= 1'b1;
            tx_data <= sr[FW-1];
          end else if (bits != '0) begin
            half    <= 1'b0;
            bits    <= bits - 1'b1;
            sr      <= {sr[FW-2:0], 1'b0};
            tx_data <= ~sr[FW-2];
          end else begin
            half     <= 1'b0;
            sr       <= '0;
            tx_valid <= 1'b0;
            tx_data  <= 1'b0;
            if (ch != 2'd2) begin
              ch    <= ch + 2'd1;
              state <= LOAD;
            end else begin
              ch         <= '0;
              frame_done <= 1'b1;
              if (continuous) begin
                state     <= CLEAR;
                cnt       <= '0;
                glen      <= glen_in;
                ctr_reset <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tros_meas_sequencer.sv
// Randomized bench for tros_meas_sequencer against a
// cycle-timeline model derived from run arithmetic.
module tb_tros_meas_sequencer;

  localparam int CL = 20;
  localparam int S  = 4;
  localparam int FW = CL + 7;
  localparam int FL = 1 + 2 * FW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [15:0]   gate_len = '0;
  logic [CL-1:0] count0 = '0;
  logic [CL-1:0] count1 = '0;
  logic [CL-1:0] count2 = '0;
  logic          ctr_reset;
  logic          latch_counter;
  logic          busy;
  logic          tx_data;
  logic          tx_valid;
  logic          frame_done;

  tros_meas_sequencer #(
    .COUNTER_LENGTH(CL),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .continuous(continuous),
    .gate_len(gate_len),
    .count0(count0),
    .count1(count1),
    .count2(count2),
    .ctr_reset(ctr_reset),
    .latch_counter(latch_counter),
    .busy(busy),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            passed = 0;
  logic [CL-1:0] tcnt [3];
  logic [FW-1:0] last_dec [3];
  bit            pend_done = 1'b0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [FW-1:0] mkframe(
    input int ch, input logic [CL-1:0] c);
    int ones;
    ones = 0;
    for (int i = 0; i < CL; i++) ones += int'(c[i]);
    return {4'b1010, 2'(ch), c, 1'(ones % 2)};
  endfunction

  function automatic logic [5:0] outs();
    return {ctr_reset, latch_counter, busy,
            tx_valid, tx_data, frame_done};
  endfunction

  task automatic drive_rand();
    start      = 1'($urandom_range(0, 1));
    continuous = 1'($urandom_range(0, 1));
    gate_len   = 16'($urandom);
    count0     = CL'($urandom);
    count1     = CL'($urandom);
    count2     = CL'($urandom);
  endtask

  task automatic rand_counts();
    for (int i = 0; i < 3; i++) tcnt[i] = CL'($urandom);
  endtask

  task automatic do_run(input int g, input bit cont,
                        input int gnext, input bit first,
                        input int abort_c);
    int            gg, b, len, r, k, o, j, nd;
    logic          bitv;
    logic [5:0]    e;
    logic [FW-1:0] fr [3];
    logic [FW-1:0] dec;
    gg  = (g == 0) ? 1 : g;
    b   = 2 + gg + S;
    len = b + 3 * FL;
    dec = '0;
    k   = 0;
    j   = 0;
    for (int i = 0; i < 3; i++) fr[i] = mkframe(i, tcnt[i]);
    if (first) begin
      @(posedge clk); #1;
      drive_rand();
      start    = 1'b1;
      gate_len = 16'(g);
      @(negedge clk);
      check("idle_pre", 64'(outs()), 64'd0);
    end
    for (int c = 1; c <= len; c++) begin
      @(posedge clk); #1;
      drive_rand();
      o = 0;
      e = '0;
      e[5] = (c <= 2);
      e[4] = (c > 2 + gg) && (c <= b);
      e[3] = 1'b1;
      e[0] = (c == 1) && pend_done;
      if (c > b) begin
        r = c - b - 1;
        k = r / FL;
        o = r % FL;
        if (o == 0) begin
          count0 = tcnt[0];
          count1 = tcnt[1];
          count2 = tcnt[2];
        end else begin
          j    = (o - 1) / 2;
          bitv = fr[k][FW-1-j];
          e[2] = 1'b1;
          e[1] = ((o - 1) % 2 == 1) ? bitv : ~bitv;
        end
      end
      if (c == len) begin
        continuous = cont;
        gate_len   = 16'(gnext);
      end
      @(negedge clk);
      check($sformatf("cyc%0d", c), 64'(outs()), 64'(e));
      if (c > b && o != 0 && (o - 1) % 2 == 1) begin
        dec = {dec[FW-2:0], tx_data};
        if (j == FW - 1) begin
          last_dec[k] = dec;
          check($sformatf("frame%0d", k), 64'(dec), 64'(fr[k]));
        end
      end
      if (c == abort_c) begin
        #2 rst_n = 1'b0;
        #1 check("rst_async", 64'(outs()), 64'd0);
        pend_done = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b0;
        return;
      end
    end
    if (cont) begin
      pend_done = 1'b1;
    end else begin
      pend_done = 1'b0;
      @(posedge clk); #1;
      drive_rand();
      start = 1'b0;
      @(negedge clk);
      check("run_end", 64'(outs()), 64'b000001);
      nd = int'(frame_done);
      @(posedge clk); #1;
      drive_rand();
      start = 1'b0;
      @(negedge clk);
      check("idle_post", 64'(outs()), 64'd0);
      nd += int'(frame_done);
      check("done_once", 64'(nd), 64'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int            g, gn;
    bit            cont, first;
    logic [FW-1:0] lit;
    lit = 27'b1010_00_00010010001101000101_1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", 64'(outs()), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    tcnt[0] = 20'h12345;
    tcnt[1] = 20'hFFFFF;
    tcnt[2] = 20'h00000;
    do_run(5, 1'b0, 0, 1'b1, -1);
    check("frame0_lit", 64'(last_dec[0]), 64'(lit));
    check("frame1_par", 64'(last_dec[1][0]), 64'd0);
    check("frame2_par", 64'(last_dec[2][0]), 64'd0);
    check("frame1_ch", 64'(last_dec[1][FW-5 -: 2]), 64'd1);
    check("frame2_ch", 64'(last_dec[2][FW-5 -: 2]), 64'd2);

    rand_counts();
    do_run(0, 1'b0, 0, 1'b1, -1);

    rand_counts();
    do_run(3, 1'b1, 7, 1'b1, -1);
    rand_counts();
    do_run(7, 1'b1, 0, 1'b0, -1);
    rand_counts();
    do_run(0, 1'b0, 0, 1'b0, -1);

    rand_counts();
    do_run(4, 1'b0, 0, 1'b1, 2 + 4 + S + 77);
    rand_counts();
    do_run(2, 1'b0, 0, 1'b1, -1);

    g = $urandom_range(0, 12);
    first = 1'b1;
    for (int it = 0; it < 8; it++) begin
      gn   = $urandom_range(0, 12);
      cont = (it == 7) ? 1'b0 : 1'($urandom_range(0, 1));
      rand_counts();
      do_run(g, cont, gn, first, -1);
      first = !cont;
      g = gn;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
